rs_station: RTL and testbench

Parametrised reservation station, the next-generation replacement for the single-ALU RS. It sits between decode/rename and one execution unit. Each entry holds an operation with two operands, tagged by ROB index. Operands wake up from two result broadcast channels (ALU and LSB). Ready entries issue oldest-first through a registered valid/ready port. The block also supports pipeline flush and reports its occupancy to decode.

---
 rtl/rs_station.sv | 202 ++++++++++++++++++++
 tb/tb_rs_station.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_station.sv
// Reservation station feeding one execution unit: operands wake from two result
// broadcasts, ready entries issue oldest-first through a registered valid/ready slot.
module rs_station #(
  parameter int ENTRIES = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int XLEN    = 32,
  parameter int CNT_W   = $clog2(ENTRIES) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rdy_i,
  input  logic             flush_i,
  input  logic             disp_valid_i,
  input  logic [OP_W-1:0]  disp_op_i,
  input  logic [ROB_W-1:0] disp_rob_i,
  input  logic             disp_q1_rdy_i,
  input  logic             disp_q2_rdy_i,
  input  logic [XLEN-1:0]  disp_v1_i,
  input  logic [XLEN-1:0]  disp_v2_i,
  input  logic [XLEN-1:0]  disp_imm_i,
  input  logic [XLEN-1:0]  disp_pc_i,
  output logic             rs_full_o,
  output logic [CNT_W-1:0] rs_count_o,
  input  logic             cdb0_valid_i,
  input  logic [ROB_W-1:0] cdb0_rob_i,
  input  logic [XLEN-1:0]  cdb0_val_i,
  input  logic             cdb1_valid_i,
  input  logic [ROB_W-1:0] cdb1_rob_i,
  input  logic [XLEN-1:0]  cdb1_val_i,
  output logic             iss_valid_o,
  input  logic             iss_ready_i,
  output logic [OP_W-1:0]  iss_op_o,
  output logic [ROB_W-1:0] iss_rob_o,
  output logic [XLEN-1:0]  iss_v1_o,
  output logic [XLEN-1:0]  iss_v2_o,
  output logic [XLEN-1:0]  iss_imm_o,
  output logic [XLEN-1:0]  iss_pc_o
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] used_q, used_d, q1_rdy_q, q1_rdy_d, q2_rdy_q, q2_rdy_d;
  logic [OP_W-1:0]    op_q  [ENTRIES];
  logic [OP_W-1:0]    op_d  [ENTRIES];
  logic [ROB_W-1:0]   rob_q [ENTRIES];
  logic [ROB_W-1:0]   rob_d [ENTRIES];
  logic [XLEN-1:0]    v1_q  [ENTRIES];
  logic [XLEN-1:0]    v1_d  [ENTRIES];
  logic [XLEN-1:0]    v2_q  [ENTRIES];
  logic [XLEN-1:0]    v2_d  [ENTRIES];
  logic [XLEN-1:0]    imm_q [ENTRIES];
  logic [XLEN-1:0]    imm_d [ENTRIES];
  logic [XLEN-1:0]    pc_q  [ENTRIES];
  logic [XLEN-1:0]    pc_d  [ENTRIES];
  // age_q[i][j] = 1 when entry i is older than entry j
  logic [ENTRIES-1:0] age_q [ENTRIES];
  logic [ENTRIES-1:0] age_d [ENTRIES];

  logic [CNT_W-1:0]   count_q, count_d;
  logic               iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]    iss_op_q, iss_op_d;
  logic [ROB_W-1:0]   iss_rob_q, iss_rob_d;
  logic [XLEN-1:0]    iss_v1_q, iss_v1_d, iss_v2_q, iss_v2_d;
  logic [XLEN-1:0]    iss_imm_q, iss_imm_d, iss_pc_q, iss_pc_d;

  logic [ENTRIES-1:0] cand, has_older, win_vec;
  logic [IDX_W-1:0]   free_idx, win_idx;
  logic               any_cand, issue_load, issue_fire, disp_fire;
  logic [XLEN:0]      disp_w1, disp_w2;

  // Returns {ready, value}; cdb0 is checked first so it wins a duplicate tag.
  function automatic logic [XLEN:0] wake(input logic rdy, input logic [XLEN-1:0] v,
                                         input logic c0v, input logic [ROB_W-1:0] c0r,
                                         input logic [XLEN-1:0] c0d, input logic c1v,
                                         input logic [ROB_W-1:0] c1r, input logic [XLEN-1:0] c1d);
    if (rdy) return {1'b1, v};
    if (c0v && (v[ROB_W-1:0] == c0r)) return {1'b1, c0d};
    if (c1v && (v[ROB_W-1:0] == c1r)) return {1'b1, c1d};
    return {1'b0, v};
  endfunction

  assign rs_full_o   = (count_q == CNT_W'(ENTRIES));
  assign rs_count_o  = count_q;
  assign iss_valid_o = iss_valid_q;
  assign iss_op_o    = iss_op_q;
  assign iss_rob_o   = iss_rob_q;
  assign iss_v1_o    = iss_v1_q;
  assign iss_v2_o    = iss_v2_q;
  assign iss_imm_o   = iss_imm_q;
  assign iss_pc_o    = iss_pc_q;

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!used_q[i]) free_idx = IDX_W'(i);

    cand     = used_q & q1_rdy_q & q2_rdy_q;
    any_cand = |cand;
    for (int i = 0; i < ENTRIES; i++) begin
      has_older[i] = 1'b0;
      for (int j = 0; j < ENTRIES; j++)
        has_older[i] = has_older[i] | (cand[j] & age_q[j][i]);
    end
    win_vec = cand & ~has_older;
    win_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (win_vec[i]) win_idx = IDX_W'(i);
  end

  assign issue_load = !iss_valid_q || iss_ready_i;
  assign issue_fire = issue_load && any_cand && !flush_i;
  assign disp_fire  = disp_valid_i && !rs_full_o && !flush_i;
  assign disp_w1 = wake(disp_q1_rdy_i, disp_v1_i, cdb0_valid_i, cdb0_rob_i, cdb0_val_i,
                        cdb1_valid_i, cdb1_rob_i, cdb1_val_i);
  assign disp_w2 = wake(disp_q2_rdy_i, disp_v2_i, cdb0_valid_i, cdb0_rob_i, cdb0_val_i,
                        cdb1_valid_i, cdb1_rob_i, cdb1_val_i);

  always_comb begin
    used_d = used_q;   q1_rdy_d = q1_rdy_q; q2_rdy_d = q2_rdy_q;
    op_d   = op_q;     rob_d    = rob_q;    v1_d     = v1_q;     v2_d = v2_q;
    imm_d  = imm_q;    pc_d     = pc_q;     age_d    = age_q;
    count_d     = count_q;
    iss_valid_d = iss_valid_q; iss_op_d  = iss_op_q;  iss_rob_d = iss_rob_q;
    iss_v1_d    = iss_v1_q;    iss_v2_d  = iss_v2_q;
    iss_imm_d   = iss_imm_q;   iss_pc_d  = iss_pc_q;

    if (flush_i) begin
      used_d      = '0;
      count_d     = '0;
      iss_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (used_q[i]) begin
          {q1_rdy_d[i], v1_d[i]} = wake(q1_rdy_q[i], v1_q[i], cdb0_valid_i, cdb0_rob_i,
                                        cdb0_val_i, cdb1_valid_i, cdb1_rob_i, cdb1_val_i);
          {q2_rdy_d[i], v2_d[i]} = wake(q2_rdy_q[i], v2_q[i], cdb0_valid_i, cdb0_rob_i,
                                        cdb0_val_i, cdb1_valid_i, cdb1_rob_i, cdb1_val_i);
        end
      end

      if (issue_load) begin
        iss_valid_d = any_cand;
        if (any_cand) begin
          iss_op_d  = op_q[win_idx];  iss_rob_d = rob_q[win_idx];
          iss_v1_d  = v1_q[win_idx];  iss_v2_d  = v2_q[win_idx];
          iss_imm_d = imm_q[win_idx]; iss_pc_d  = pc_q[win_idx];
          used_d[win_idx] = 1'b0;
        end
      end

      if (disp_fire) begin
        used_d[free_idx] = 1'b1;
        op_d[free_idx]   = disp_op_i;
        rob_d[free_idx]  = disp_rob_i;
        {q1_rdy_d[free_idx], v1_d[free_idx]} = disp_w1;
        {q2_rdy_d[free_idx], v2_d[free_idx]} = disp_w2;
        imm_d[free_idx]  = disp_imm_i;
        pc_d[free_idx]   = disp_pc_i;
        age_d[free_idx]  = '0;
        for (int i = 0; i < ENTRIES; i++)
          if (used_q[i] && (IDX_W'(i) != free_idx)) age_d[i][free_idx] = 1'b1;
      end

      count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      used_q      <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_rob_q   <= '0;
      iss_v1_q    <= '0;
      iss_v2_q    <= '0;
      iss_imm_q   <= '0;
      iss_pc_q    <= '0;
    end else if (rdy_i) begin
      used_q      <= used_d;
      q1_rdy_q    <= q1_rdy_d;
      q2_rdy_q    <= q2_rdy_d;
      op_q        <= op_d;
      rob_q       <= rob_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      age_q       <= age_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_rob_q   <= iss_rob_d;
      iss_v1_q    <= iss_v1_d;
      iss_v2_q    <= iss_v2_d;
      iss_imm_q   <= iss_imm_d;
      iss_pc_q    <= iss_pc_d;
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: latency, wakeup, age ordering, full, flush and stall.
module tb_rs_station;
  localparam int ENTRIES = 16, ROB_W = 4, OP_W = 6, XLEN = 32, CNT_W = 5;

  logic clk = 1'b0;
  logic rst, rdy, flush, disp_valid, disp_q1_rdy, disp_q2_rdy;
  logic [OP_W-1:0]  disp_op;
  logic [ROB_W-1:0] disp_rob;
  logic [XLEN-1:0]  disp_v1, disp_v2, disp_imm, disp_pc;
  logic             rs_full;
  logic [CNT_W-1:0] rs_count;
  logic             cdb0_valid, cdb1_valid;
  logic [ROB_W-1:0] cdb0_rob, cdb1_rob;
  logic [XLEN-1:0]  cdb0_val, cdb1_val;
  logic             iss_valid, iss_ready;
  logic [OP_W-1:0]  iss_op;
  logic [ROB_W-1:0] iss_rob;
  logic [XLEN-1:0]  iss_v1, iss_v2, iss_imm, iss_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rs_station #(.ENTRIES(ENTRIES), .ROB_W(ROB_W), .OP_W(OP_W), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .rdy_i(rdy), .flush_i(flush),
    .disp_valid_i(disp_valid), .disp_op_i(disp_op), .disp_rob_i(disp_rob),
    .disp_q1_rdy_i(disp_q1_rdy), .disp_q2_rdy_i(disp_q2_rdy),
    .disp_v1_i(disp_v1), .disp_v2_i(disp_v2), .disp_imm_i(disp_imm), .disp_pc_i(disp_pc),
    .rs_full_o(rs_full), .rs_count_o(rs_count),
    .cdb0_valid_i(cdb0_valid), .cdb0_rob_i(cdb0_rob), .cdb0_val_i(cdb0_val),
    .cdb1_valid_i(cdb1_valid), .cdb1_rob_i(cdb1_rob), .cdb1_val_i(cdb1_val),
    .iss_valid_o(iss_valid), .iss_ready_i(iss_ready),
    .iss_op_o(iss_op), .iss_rob_o(iss_rob), .iss_v1_o(iss_v1), .iss_v2_o(iss_v2),
    .iss_imm_o(iss_imm), .iss_pc_o(iss_pc)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                      input logic r1, input logic [XLEN-1:0] v1,
                      input logic r2, input logic [XLEN-1:0] v2);
    disp_valid = 1'b1; disp_op = op; disp_rob = rob;
    disp_q1_rdy = r1; disp_v1 = v1; disp_q2_rdy = r2; disp_v2 = v2;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; iss_ready = 1'b1;
    disp_valid = 1'b0; disp_op = '0; disp_rob = '0; disp_q1_rdy = 1'b0; disp_q2_rdy = 1'b0;
    disp_v1 = '0; disp_v2 = '0; disp_imm = '0; disp_pc = '0;
    cdb0_valid = 1'b0; cdb0_rob = '0; cdb0_val = '0;
    cdb1_valid = 1'b0; cdb1_rob = '0; cdb1_val = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_count", 32'(rs_count), 0);
    chk("rst_full", 32'(rs_full), 0);
    chk("rst_iss_op", 32'(iss_op), 0);
    chk("rst_iss_rob", 32'(iss_rob), 0);
    chk("rst_iss_v1", iss_v1, 0);
    chk("rst_iss_pc", iss_pc, 0);

    // ready operands: dispatch at edge N, issue at N+1
    disp(6'd3, 4'd5, 1'b1, 32'd10, 1'b1, 32'd20);
    disp_imm = 32'h111; disp_pc = 32'h200;
    step();
    disp_valid = 1'b0;
    chk("t1_count_after_disp", 32'(rs_count), 1);
    chk("t1_not_yet_valid", 32'(iss_valid), 0);
    step();
    chk("t1_iss_valid", 32'(iss_valid), 1);
    chk("t1_iss_op", 32'(iss_op), 3);
    chk("t1_iss_rob", 32'(iss_rob), 5);
    chk("t1_iss_v1", iss_v1, 10);
    chk("t1_iss_v2", iss_v2, 20);
    chk("t1_iss_imm", iss_imm, 32'h111);
    chk("t1_iss_pc", iss_pc, 32'h200);
    chk("t1_count_zero", 32'(rs_count), 0);
    step();
    chk("t1_iss_drained", 32'(iss_valid), 0);

    // q1 pending on tag 7, woken by cdb1
    disp(6'd1, 4'd2, 1'b0, 32'd7, 1'b1, 32'd5);
    step();
    disp_valid = 1'b0;
    step();
    chk("t2_pending_no_issue", 32'(iss_valid), 0);
    cdb1_valid = 1'b1; cdb1_rob = 4'd7; cdb1_val = 32'hDEAD;
    step();
    cdb1_valid = 1'b0;
    chk("t2_wake_edge_no_issue", 32'(iss_valid), 0);
    step();
    chk("t2_iss_valid", 32'(iss_valid), 1);
    chk("t2_iss_rob", 32'(iss_rob), 2);
    chk("t2_iss_v1_cdb1", iss_v1, 32'hDEAD);
    chk("t2_iss_v2", iss_v2, 5);
    step();

    // same with cdb0
    disp(6'd1, 4'd2, 1'b0, 32'd7, 1'b1, 32'd5);
    step();
    disp_valid = 1'b0;
    cdb0_valid = 1'b1; cdb0_rob = 4'd7; cdb0_val = 32'hBEEF;
    step();
    cdb0_valid = 1'b0;
    chk("t2b_wake_edge_no_issue", 32'(iss_valid), 0);
    step();
    chk("t2b_iss_valid", 32'(iss_valid), 1);
    chk("t2b_iss_v1_cdb0", iss_v1, 32'hBEEF);
    step();

    // age order: rob1, rob2, rob3 pending; wake rob3 and rob1 together
    disp(6'd4, 4'd1, 1'b0, 32'd11, 1'b1, 32'd0); step();
    disp(6'd4, 4'd2, 1'b0, 32'd12, 1'b1, 32'd0); step();
    disp(6'd4, 4'd3, 1'b0, 32'd13, 1'b1, 32'd0); step();
    disp_valid = 1'b0;
    chk("t3_count3", 32'(rs_count), 3);
    cdb0_valid = 1'b1; cdb0_rob = 4'd13; cdb0_val = 32'h33;
    cdb1_valid = 1'b1; cdb1_rob = 4'd11; cdb1_val = 32'h11;
    step();
    cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    chk("t3_no_issue_yet", 32'(iss_valid), 0);
    step();
    chk("t3_first_rob", 32'(iss_rob), 1);
    chk("t3_first_v1", iss_v1, 32'h11);
    chk("t3_count2", 32'(rs_count), 2);
    step();
    chk("t3_second_rob", 32'(iss_rob), 3);
    chk("t3_second_v1", iss_v1, 32'h33);
    chk("t3_count1", 32'(rs_count), 1);
    step();
    chk("t3_rob2_never", 32'(iss_valid), 0);
    chk("t3_rob2_stays", 32'(rs_count), 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("t3_flush_count", 32'(rs_count), 0);

    // fill with issue stalled: first op sits in the issue register, 16 more fill the station
    iss_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      disp(6'd2, 4'(i), 1'b1, 32'(i), 1'b1, 32'd0);
      step();
    end
    chk("t4_full", 32'(rs_full), 1);
    chk("t4_count16", 32'(rs_count), 16);
    disp(6'd2, 4'd1, 1'b1, 32'd17, 1'b1, 32'd0);
    step();
    disp_valid = 1'b0;
    chk("t4_extra_ignored", 32'(rs_count), 16);
    chk("t4_still_full", 32'(rs_full), 1);
    chk("t4_held_valid", 32'(iss_valid), 1);
    chk("t4_held_v1", iss_v1, 0);
    iss_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t4_drain_v1", iss_v1, 32'(k));
      chk("t4_drain_count", 32'(rs_count), 32'(16 - k));
    end
    step();
    chk("t4_empty_valid", 32'(iss_valid), 0);
    chk("t4_not_full", 32'(rs_full), 0);

    // dispatch-cycle bypass from cdb0
    disp(6'd5, 4'd6, 1'b0, 32'd4, 1'b1, 32'd1);
    cdb0_valid = 1'b1; cdb0_rob = 4'd4; cdb0_val = 32'd99;
    step();
    disp_valid = 1'b0; cdb0_valid = 1'b0;
    step();
    chk("t5_iss_valid", 32'(iss_valid), 1);
    chk("t5_iss_rob", 32'(iss_rob), 6);
    chk("t5_bypass_v1", iss_v1, 99);
    step();

    // flush with 5 held entries plus a stalled issue
    iss_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      disp(6'd1, 4'(i), 1'b1, 32'(i + 100), 1'b1, 32'd0);
      step();
    end
    disp_valid = 1'b0;
    chk("t6_count5", 32'(rs_count), 5);
    chk("t6_valid_before_flush", 32'(iss_valid), 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("t6_flush_count", 32'(rs_count), 0);
    chk("t6_flush_valid", 32'(iss_valid), 0);
    cdb0_valid = 1'b1; cdb0_rob = 4'd3; cdb0_val = 32'd1;
    step();
    cdb0_valid = 1'b0;
    chk("t6_stale_cdb", 32'(rs_count), 0);
    chk("t6_stale_valid", 32'(iss_valid), 0);

    // rdy low freezes everything, including iss_ready and dispatch
    disp(6'd1, 4'd8, 1'b1, 32'd8, 1'b1, 32'd0); step();
    disp(6'd1, 4'd9, 1'b1, 32'd9, 1'b1, 32'd0); step();
    chk("t7_count1", 32'(rs_count), 1);
    chk("t7_rob8", 32'(iss_rob), 8);
    rdy = 1'b0; iss_ready = 1'b1;
    disp(6'd1, 4'd10, 1'b1, 32'd10, 1'b1, 32'd0);
    cdb0_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t7_frozen_count", 32'(rs_count), 1);
      chk("t7_frozen_valid", 32'(iss_valid), 1);
      chk("t7_frozen_rob", 32'(iss_rob), 8);
    end
    rdy = 1'b1; disp_valid = 1'b0; cdb0_valid = 1'b0;
    step();
    chk("t7_resume_rob", 32'(iss_rob), 9);
    chk("t7_resume_count", 32'(rs_count), 0);
    step();
    chk("t7_final_valid", 32'(iss_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
